// File: rtl/output_port_if.sv
// VOQ read port plus outgoing link handshake for one router output.
// master = the output_port scheduler, slave = the VOQ/link side.
interface output_port_if #(
    parameter int NUM_INPUTS   = 12,
    parameter int PACKET_WIDTH = 128
);
    logic                    link_up;
    logic [NUM_INPUTS-1:0]   voq_empty;
    logic [PACKET_WIDTH-1:0] voq_rd_data [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]   voq_rd_en;
    logic                    out_valid;
    logic [PACKET_WIDTH-1:0] out_packet;
    logic                    out_ready;
    logic [31:0]             pkt_count;

    modport master (
        input  link_up, voq_empty, voq_rd_data, out_ready,
        output voq_rd_en, out_valid, out_packet, pkt_count
    );

    modport slave (
        output link_up, voq_empty, voq_rd_data, out_ready,
        input  voq_rd_en, out_valid, out_packet, pkt_count
    );
endinterface

// File: rtl/output_port.sv
// Round-robin VOQ scheduler feeding a small FIFO output buffer that drives
// the outgoing link with a valid/ready handshake.
module output_port #(
    parameter int NUM_INPUTS   = 12,
    parameter int PACKET_WIDTH = 128,
    parameter int OBUF_DEPTH   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    output_port_if.master bus
);
    localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int OB_W  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

    logic [PTR_W-1:0]        r_rr_ptr;
    logic                    r_inflight;
    logic [PTR_W-1:0]        r_inflight_idx;
    logic [PACKET_WIDTH-1:0] r_obuf [OBUF_DEPTH];
    logic [OB_W-1:0]         r_head;
    logic [OB_W-1:0]         r_tail;
    logic [CNT_W-1:0]        r_obuf_cnt;
    logic [31:0]             r_pkt_count;

    logic [NUM_INPUTS-1:0]   w_nonempty;
    logic                    w_grant_valid;
    logic [PTR_W-1:0]        w_grant_idx;
    logic [PTR_W:0]          w_sum;
    logic [PTR_W-1:0]        w_cand;
    logic [CNT_W:0]          w_occupancy;
    logic                    w_issue;
    logic [PTR_W-1:0]        w_rr_next;
    logic                    w_out_valid;
    logic                    w_pop;

    function automatic logic [OB_W-1:0] ob_inc(input logic [OB_W-1:0] p);
        return (p == OB_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_nonempty = ~bus.voq_empty;

    // Scan offsets from the far end so the closest non-empty VOQ to rr_ptr wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_sum         = '0;
        w_cand        = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= (PTR_W + 1)'(NUM_INPUTS))
                w_sum = w_sum - (PTR_W + 1)'(NUM_INPUTS);
            w_cand = w_sum[PTR_W-1:0];
            if (w_nonempty[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // An inflight read already owns a buffer slot, so it counts as occupancy.
    assign w_occupancy = {1'b0, r_obuf_cnt} + (CNT_W + 1)'(r_inflight);
    assign w_issue     = rst_n && bus.link_up && w_grant_valid &&
                         (w_occupancy < (CNT_W + 1)'(OBUF_DEPTH));
    assign w_rr_next   = (w_grant_idx == PTR_W'(NUM_INPUTS - 1)) ? '0 : w_grant_idx + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_rd_en
            assign bus.voq_rd_en[gi] = w_issue && (w_grant_idx == PTR_W'(gi));
        end
    endgenerate

    assign w_out_valid    = (r_obuf_cnt != '0) && bus.link_up;
    assign w_pop          = w_out_valid && bus.out_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_packet = r_obuf[r_head];
    assign bus.pkt_count  = r_pkt_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= '0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_obuf_cnt     <= '0;
            r_pkt_count    <= '0;
            for (int k = 0; k < OBUF_DEPTH; k++)
                r_obuf[k] <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rr_ptr       <= w_rr_next;
                r_inflight_idx <= w_grant_idx;
            end
            // VOQ data arrives the cycle after its pop; capture even with link down.
            if (r_inflight) begin
                r_obuf[r_tail] <= bus.voq_rd_data[r_inflight_idx];
                r_tail         <= ob_inc(r_tail);
            end
            if (w_pop) begin
                r_head      <= ob_inc(r_head);
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_obuf_cnt <= r_obuf_cnt + 1'b1;
                2'b01:   r_obuf_cnt <= r_obuf_cnt - 1'b1;
                default: r_obuf_cnt <= r_obuf_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_output_port.sv
// Directed and random checks of output_port against a behavioural VOQ model.
module tb_output_port;
    localparam int N = 12;
    localparam int W = 128;
    localparam int D = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    output_port_if #(.NUM_INPUTS(N), .PACKET_WIDTH(W)) bus ();

    output_port #(.NUM_INPUTS(N), .PACKET_WIDTH(W), .OBUF_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input int v, input int s);
        return {64'hC0DE_0000_0000_0000, 32'(v), 32'(s)};
    endfunction

    // VOQ model: pop on rd_en, data valid next cycle, registered empty flags
    logic [W-1:0] voq_q [N][$];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.voq_rd_en[i] && voq_q[i].size() > 0)
                bus.voq_rd_data[i] <= voq_q[i].pop_front();
            bus.voq_empty[i] <= (voq_q[i].size() == 0);
        end
    end

    // Monitor: grants and link transfers, sampled just before the rising edge
    int           cyc = 0;
    int           g_idx [$];
    int           g_cyc [$];
    logic [N-1:0] g_vec [$];
    logic [W-1:0] x_pkt [$];
    int           x_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int idx;
        #4;
        if (bus.voq_rd_en != '0) begin
            idx = 0;
            for (int i = 0; i < N; i++)
                if (bus.voq_rd_en[i]) idx = i;
            check("rd_en_onehot", W'($onehot(bus.voq_rd_en)), W'(1));
            check("rd_en_to_empty", W'(bus.voq_rd_en & bus.voq_empty), W'(0));
            g_idx.push_back(idx);
            g_cyc.push_back(cyc);
            g_vec.push_back(bus.voq_rd_en);
            $display("grant cyc=%0d voq=%0d", cyc, idx);
        end
        if (bus.out_valid && bus.out_ready) begin
            x_pkt.push_back(bus.out_packet);
            x_cyc.push_back(cyc);
            $display("xfer  cyc=%0d pkt=%h", cyc, bus.out_packet);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        g_idx.delete(); g_cyc.delete(); g_vec.delete();
        x_pkt.delete(); x_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.link_up = 1'b1;
        bus.out_ready = 1'b0;
        run(2);
        clear_logs();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_g [6];
        int t, bad, sent, v, s;
        int sent_seq [N];
        int rcv_seq  [N];

        rst_n = 1'b0;
        bus.link_up = 1'b1;
        bus.out_ready = 1'b0;
        bus.voq_empty = '1;
        for (int i = 0; i < N; i++) bus.voq_rd_data[i] = '0;

        // reset state
        @(negedge clk); #1;
        check("rst_rd_en", W'(bus.voq_rd_en), W'(0));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_out_packet", bus.out_packet, W'(0));
        check("rst_pkt_count", W'(bus.pkt_count), W'(0));

        // single packet through VOQ 5
        do_reset();
        bus.out_ready = 1'b1;
        voq_q[5].push_back({16{8'hA5}});
        run(8);
        check("t1_num_grants", W'(g_vec.size()), W'(1));
        if (g_vec.size() > 0) check("t1_rd_en", W'(g_vec[0]), W'(12'h020));
        check("t1_num_xfers", W'(x_pkt.size()), W'(1));
        if (x_pkt.size() > 0 && g_cyc.size() > 0) begin
            check("t1_packet", x_pkt[0], {16{8'hA5}});
            check("t1_latency", W'(x_cyc[0] - g_cyc[0]), W'(2));
        end
        check("t1_pkt_count", W'(bus.pkt_count), W'(1));

        // round robin over VOQs 0, 3, 11
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            voq_q[0].push_back(mk(0, k));
            voq_q[3].push_back(mk(3, k));
            voq_q[11].push_back(mk(11, k));
        end
        run(12);
        exp_g = '{0, 3, 11, 0, 3, 11};
        check("t2_num_grants", W'(g_idx.size()), W'(6));
        check("t2_num_xfers", W'(x_pkt.size()), W'(6));
        if (g_idx.size() == 6 && x_pkt.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                check("t2_grant_order", W'(g_idx[k]), W'(exp_g[k]));
                check("t2_pkt_order", x_pkt[k], mk(exp_g[k], k / 3));
            end
            check("t2_grant_b2b", W'(g_cyc[5] - g_cyc[0]), W'(5));
            check("t2_xfer_b2b", W'(x_cyc[5] - x_cyc[0]), W'(5));
        end
        check("t2_pkt_count", W'(bus.pkt_count), W'(6));

        // backpressure on VOQ 2
        do_reset();
        for (int k = 1; k <= 5; k++) voq_q[2].push_back(mk(2, k));
        run(10);
        check("t3_pops_blocked", W'(g_idx.size()), W'(3));
        check("t3_rd_en_idle", W'(bus.voq_rd_en), W'(0));
        check("t3_head_held", bus.out_packet, mk(2, 1));
        check("t3_valid_held", W'(bus.out_valid), W'(1));
        check("t3_no_xfer", W'(x_pkt.size()), W'(0));
        bus.out_ready = 1'b1;
        run(12);
        check("t3_num_xfers", W'(x_pkt.size()), W'(5));
        if (x_pkt.size() == 5)
            for (int k = 0; k < 5; k++) check("t3_pkt_order", x_pkt[k], mk(2, k + 1));
        check("t3_pkt_count", W'(bus.pkt_count), W'(5));

        // link down with two buffered packets and VOQ 7 waiting
        do_reset();
        voq_q[1].push_back(mk(1, 1));
        voq_q[1].push_back(mk(1, 2));
        run(6);
        check("t4_buffered_valid", W'(bus.out_valid), W'(1));
        bus.link_up = 1'b0;
        bus.out_ready = 1'b1;
        voq_q[7].push_back(mk(7, 1));
        clear_logs();
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (bus.out_valid) bad = 1;
        end
        check("t4_valid_low", W'(bad), W'(0));
        check("t4_no_grant", W'(g_idx.size()), W'(0));
        check("t4_no_xfer", W'(x_pkt.size()), W'(0));
        bus.link_up = 1'b1;
        run(8);
        check("t4_num_xfers", W'(x_pkt.size()), W'(3));
        if (x_pkt.size() == 3) begin
            check("t4_first", x_pkt[0], mk(1, 1));
            check("t4_second", x_pkt[1], mk(1, 2));
            check("t4_third", x_pkt[2], mk(7, 1));
        end

        // reset with two buffered and one inflight
        do_reset();
        for (int k = 0; k < 3; k++) voq_q[4].push_back(mk(4, k));
        t = 0;
        while (g_idx.size() < 3 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t5_reach_grants", W'(g_idx.size()), W'(3));
        check("t5_pre_valid", W'(bus.out_valid), W'(1));
        rst_n = 1'b0;
        voq_q[6].push_back(mk(6, 9));
        voq_q[2].push_back(mk(2, 9));
        #1;
        check("t5_rst_rd_en", W'(bus.voq_rd_en), W'(0));
        check("t5_rst_valid", W'(bus.out_valid), W'(0));
        check("t5_rst_packet", bus.out_packet, W'(0));
        check("t5_rst_count", W'(bus.pkt_count), W'(0));
        clear_logs();
        run(3);
        check("t5_no_grant_in_rst", W'(g_idx.size()), W'(0));
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        run(8);
        if (g_idx.size() > 0) check("t5_first_grant", W'(g_idx[0]), W'(2));
        check("t5_num_xfers", W'(x_pkt.size()), W'(2));
        if (x_pkt.size() == 2) begin
            check("t5_first", x_pkt[0], mk(2, 9));
            check("t5_second", x_pkt[1], mk(6, 9));
        end

        // random scoreboard: 200 packets, random VOQs, random out_ready
        do_reset();
        for (int i = 0; i < N; i++) begin
            sent_seq[i] = 0;
            rcv_seq[i] = 0;
        end
        sent = 0;
        t = 0;
        while (x_pkt.size() < 200 && t < 3000) begin
            @(negedge clk);
            t++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 200 && $urandom_range(0, 1) == 1) begin
                v = $urandom_range(0, N - 1);
                voq_q[v].push_back(mk(v, sent_seq[v]));
                sent_seq[v]++;
                sent++;
            end
        end
        run(4);
        check("t6_num_xfers", W'(x_pkt.size()), W'(200));
        check("t6_pkt_count", W'(bus.pkt_count), W'(200));
        for (int k = 0; k < x_pkt.size(); k++) begin
            v = int'(x_pkt[k][63:32]);
            s = int'(x_pkt[k][31:0]);
            check("t6_header", W'(x_pkt[k][127:64]), W'(64'hC0DE_0000_0000_0000));
            if (v >= 0 && v < N) begin
                check("t6_voq_order", W'(s), W'(rcv_seq[v]));
                rcv_seq[v]++;
            end else begin
                check("t6_voq_range", W'(v), W'(N - 1));
            end
        end
        for (int i = 0; i < N; i++) check("t6_voq_total", W'(rcv_seq[i]), W'(sent_seq[i]));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
